// File: rtl/reimu_shot_ctrl.sv
// Player shot scheduler: NSLOT bullet slots fed by one fire input, advanced per frame
// tick with zone-dependent speed, retired off-screen or on boss contact.
module reimu_shot_ctrl #(
  parameter int unsigned NSLOT    = 4,
  parameter int unsigned COOLDOWN = 8,
  parameter logic [9:0]  BOSS_HP  = 10'd200,
  parameter int unsigned DMG      = 2,
  parameter int unsigned HALF_W   = 41,
  parameter int unsigned HALF_H   = 24
) (
  input  logic                  clk_22,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  fire,
  input  logic [9:0]            reimux,
  input  logic [9:0]            reimuy,
  input  logic [9:0]            bossx,
  input  logic [9:0]            bossy,
  output logic [NSLOT*10-1:0]   slot_x,
  output logic [NSLOT*10-1:0]   slot_y,
  output logic [NSLOT-1:0]      slot_active,
  output logic [9:0]            boss_hp,
  output logic                  hit_pulse,
  output logic                  boss_defeated
);

  localparam int unsigned CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  typedef enum logic {ACTIVE, DEFEATED} state_t;

  state_t           state;
  logic [9:0]       sx [NSLOT];
  logic [9:0]       sy [NSLOT];
  logic [NSLOT-1:0] act;
  logic [9:0]       hp;
  logic [CW-1:0]    cd;

  logic [NSLOT-1:0] hit_vec;
  logic [9:0]       step [NSLOT];
  logic [9:0]       nx_x [NSLOT];
  logic [9:0]       nx_y [NSLOT];
  logic [NSLOT-1:0] nx_act;
  logic [3:0]       hits;
  logic [15:0]      dmg;
  logic [9:0]       hp_next;
  logic             defeat;
  logic             spawn_ok;
  logic             taken;
  logic [CW-1:0]    cd_next;

  // Hit test widened to 11 bits so boxes near the screen edge cannot underflow.
  always_comb begin
    for (int unsigned i = 0; i < NSLOT; i++) begin
      hit_vec[i] = act[i]
                && (({1'b0, sx[i]} + 11'(HALF_W)) >= {1'b0, bossx})
                && ({1'b0, sx[i]} <= ({1'b0, bossx} + 11'(HALF_W)))
                && (({1'b0, sy[i]} + 11'(HALF_H)) >= {1'b0, bossy})
                && ({1'b0, sy[i]} <= ({1'b0, bossy} + 11'(HALF_H)));
      step[i] = (sy[i] <= 10'd120) ? 10'd1 :
                (sy[i] <= 10'd240) ? 10'd2 : 10'd4;
    end
  end

  always_comb begin
    hits   = '0;
    nx_act = act;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      nx_x[i] = sx[i];
      nx_y[i] = sy[i];
      if (act[i]) begin
        if (hit_vec[i]) begin
          nx_act[i] = 1'b0;
          hits      = hits + 4'd1;
        end else if (sy[i] <= step[i]) begin
          nx_act[i] = 1'b0;
        end else begin
          nx_y[i] = sy[i] - step[i];
        end
      end
    end

    dmg     = 16'(hits) * 16'(DMG);
    hp_next = (16'(hp) > dmg) ? (hp - dmg[9:0]) : '0;
    defeat  = (hp_next == '0);

    // Free slots are judged on pre-tick occupancy, so this tick's retirements stay unusable.
    spawn_ok = fire && (cd == '0) && !defeat;
    taken    = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (spawn_ok && !act[i] && !taken) begin
        nx_x[i]   = reimux;
        nx_y[i]   = reimuy;
        nx_act[i] = 1'b1;
        taken     = 1'b1;
      end
    end

    if (taken)
      cd_next = CW'(COOLDOWN);
    else if (cd != '0)
      cd_next = cd - CW'(1);
    else
      cd_next = cd;
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      state         <= ACTIVE;
      act           <= '0;
      hp            <= BOSS_HP;
      cd            <= '0;
      hit_pulse     <= 1'b0;
      boss_defeated <= 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else begin
      hit_pulse <= 1'b0;
      if (tick) begin
        case (state)
          ACTIVE: begin
            sx        <= nx_x;
            sy        <= nx_y;
            hp        <= hp_next;
            cd        <= cd_next;
            hit_pulse <= (hits != '0);
            if (defeat) begin
              state         <= DEFEATED;
              act           <= '0;
              boss_defeated <= 1'b1;
            end else begin
              act <= nx_act;
            end
          end
          DEFEATED: begin
            act <= '0;
            hp  <= '0;
          end
          default: state <= ACTIVE;
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NSLOT; i++) begin
      slot_x[10*i +: 10] = sx[i];
      slot_y[10*i +: 10] = sy[i];
    end
  end

  assign slot_active = act;
  assign boss_hp     = hp;

endmodule

// File: tb/tb_reimu_shot_ctrl.sv
// Directed bench for reimu_shot_ctrl: flight profile, cooldown spacing, hits, defeat, reset.
module tb_reimu_shot_ctrl;

  logic        clk_22 = 1'b0;
  logic        rst, tick, fire;
  logic [9:0]  reimux, reimuy, bossx, bossy;
  logic [39:0] slot_x, slot_y;
  logic [3:0]  slot_active;
  logic [9:0]  boss_hp;
  logic        hit_pulse, boss_defeated;

  int tests = 0;
  int fails = 0;

  always #5 clk_22 = ~clk_22;

  reimu_shot_ctrl #(.BOSS_HP(10'd7)) dut (
    .clk_22(clk_22), .rst(rst), .tick(tick), .fire(fire),
    .reimux(reimux), .reimuy(reimuy), .bossx(bossx), .bossy(bossy),
    .slot_x(slot_x), .slot_y(slot_y), .slot_active(slot_active),
    .boss_hp(boss_hp), .hit_pulse(hit_pulse), .boss_defeated(boss_defeated)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ys(input int i);
    return slot_y[10*i +: 10];
  endfunction

  function automatic logic [9:0] xs(input int i);
    return slot_x[10*i +: 10];
  endfunction

  task automatic do_tick(input logic f);
    @(negedge clk_22);
    tick = 1'b1;
    fire = f;
    @(negedge clk_22);
    tick = 1'b0;
    fire = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_22);
    rst  = 1'b1;
    tick = 1'b1;
    fire = 1'b1;
    @(negedge clk_22);
    rst  = 1'b0;
    tick = 1'b0;
    fire = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; fire = 1'b0;
    reimux = 10'd100; reimuy = 10'd300; bossx = 10'd600; bossy = 10'd10;
    do_reset();
    chk("rst_active", 32'(slot_active), 32'd0);
    chk("rst_x", 32'(slot_x), 32'd0);
    chk("rst_y", 32'(slot_y), 32'd0);
    chk("rst_hp", 32'(boss_hp), 32'd7);
    chk("rst_pulse", 32'(hit_pulse), 32'd0);
    chk("rst_defeated", 32'(boss_defeated), 32'd0);

    // Flight profile from y=300: 4/tick above 240, 2/tick above 120, then 1/tick.
    do_tick(1'b1);
    chk("spawn_active", 32'(slot_active), 32'd1);
    chk("spawn_x", 32'(xs(0)), 32'd100);
    chk("spawn_y", 32'(ys(0)), 32'd300);
    for (int n = 1; n <= 195; n++) begin
      do_tick(1'b0);
      if (n == 1)   chk("fly_y1", 32'(ys(0)), 32'd296);
      if (n == 15)  chk("fly_y15", 32'(ys(0)), 32'd240);
      if (n == 16)  chk("fly_y16", 32'(ys(0)), 32'd238);
      if (n == 75)  chk("fly_y75", 32'(ys(0)), 32'd120);
      if (n == 76)  chk("fly_y76", 32'(ys(0)), 32'd119);
      if (n == 194) begin
        chk("fly_y194", 32'(ys(0)), 32'd1);
        chk("fly_live194", 32'(slot_active), 32'd1);
      end
      if (n == 195) chk("fly_retired", 32'(slot_active), 32'd0);
    end
    chk("fly_hp", 32'(boss_hp), 32'd7);
    chk("fly_pulse", 32'(hit_pulse), 32'd0);

    // Fire held: spawns every 9 ticks; slot 0 retires at tick 31 and is reused at 37.
    do_reset();
    reimuy = 10'd30;
    for (int t = 1; t <= 40; t++) begin
      do_tick(1'b1);
      if (t == 1)  chk("cd_t1", 32'(slot_active), 32'd1);
      if (t == 9)  chk("cd_t9", 32'(slot_active), 32'd1);
      if (t == 10) chk("cd_t10", 32'(slot_active), 32'd3);
      if (t == 19) chk("cd_t19", 32'(slot_active), 32'd7);
      if (t == 28) chk("cd_t28", 32'(slot_active), 32'd15);
      if (t == 31) chk("cd_t31", 32'(slot_active), 32'd14);
      if (t == 36) chk("cd_t36", 32'(slot_active), 32'd14);
      if (t == 37) begin
        chk("cd_t37", 32'(slot_active), 32'd15);
        chk("cd_t37_y0", 32'(ys(0)), 32'd30);
        chk("cd_t37_y1", 32'(ys(1)), 32'd3);
      end
      if (t == 40) chk("cd_t40", 32'(slot_active), 32'd13);
    end

    // Bullet climbs into boss box; first hit when pre-tick y = 84.
    do_reset();
    bossx = 10'd320; bossy = 10'd60; reimux = 10'd320; reimuy = 10'd100;
    do_tick(1'b1);
    idle(16);
    chk("hit_pre_y", 32'(ys(0)), 32'd84);
    chk("hit_pre_act", 32'(slot_active), 32'd1);
    chk("hit_pre_hp", 32'(boss_hp), 32'd7);
    do_tick(1'b0);
    chk("hit_act", 32'(slot_active), 32'd0);
    chk("hit_hp", 32'(boss_hp), 32'd5);
    chk("hit_pulse_hi", 32'(hit_pulse), 32'd1);
    @(negedge clk_22);
    chk("hit_pulse_lo", 32'(hit_pulse), 32'd0);

    // Two single hits (7->5->3), then a double hit saturates to 0.
    do_reset();
    reimuy = 10'd70;
    do_tick(1'b1);
    do_tick(1'b0);
    chk("dbl_hp5", 32'(boss_hp), 32'd5);
    idle(7);
    do_tick(1'b1);
    do_tick(1'b0);
    chk("dbl_hp3", 32'(boss_hp), 32'd3);
    idle(7);
    bossx = 10'd600; reimuy = 10'd200;
    do_tick(1'b1);
    idle(8);
    do_tick(1'b1);
    chk("dbl_pre_act", 32'(slot_active), 32'd3);
    chk("dbl_pre_y0", 32'(ys(0)), 32'd182);
    chk("dbl_pre_y1", 32'(ys(1)), 32'd200);
    bossx = 10'd320; bossy = 10'd190;
    do_tick(1'b1);
    chk("dbl_hp0", 32'(boss_hp), 32'd0);
    chk("dbl_defeated", 32'(boss_defeated), 32'd1);
    chk("dbl_act", 32'(slot_active), 32'd0);
    chk("dbl_pulse", 32'(hit_pulse), 32'd1);
    bossx = 10'd600;
    for (int k = 0; k < 10; k++) do_tick(1'b1);
    chk("def_act", 32'(slot_active), 32'd0);
    chk("def_hp", 32'(boss_hp), 32'd0);
    chk("def_flag", 32'(boss_defeated), 32'd1);

    // Left-edge boss: x=0 still hits bossx=20, x=62 is just outside.
    do_reset();
    bossx = 10'd20; bossy = 10'd60; reimux = 10'd0; reimuy = 10'd70;
    do_tick(1'b1);
    do_tick(1'b0);
    chk("edge_hit_act", 32'(slot_active), 32'd0);
    chk("edge_hit_hp", 32'(boss_hp), 32'd5);
    idle(7);
    reimux = 10'd62;
    do_tick(1'b1);
    do_tick(1'b0);
    chk("edge_miss_act", 32'(slot_active), 32'd1);
    chk("edge_miss_y", 32'(ys(0)), 32'd69);
    chk("edge_miss_hp", 32'(boss_hp), 32'd5);

    // Reset with three slots in flight; the tick on the reset cycle is ignored.
    do_reset();
    bossx = 10'd600; bossy = 10'd10; reimux = 10'd100; reimuy = 10'd300;
    for (int t = 1; t <= 19; t++) do_tick(1'b1);
    chk("mid_act", 32'(slot_active), 32'd7);
    do_reset();
    chk("mid_rst_act", 32'(slot_active), 32'd0);
    chk("mid_rst_x", 32'(slot_x), 32'd0);
    chk("mid_rst_y", 32'(slot_y), 32'd0);
    chk("mid_rst_hp", 32'(boss_hp), 32'd7);
    chk("mid_rst_pulse", 32'(hit_pulse), 32'd0);
    @(negedge clk_22);
    chk("mid_rst_hold", 32'(slot_active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reimu_shot_ctrl.md
Name: reimu_shot_ctrl

Overview:
- Scheduler for the player's shot resource: a pool of NSLOT independent bullets sharing one fire input.
- On each frame tick it allocates free slots on fire (rate-limited by a cooldown), advances live bullets upward with zone-dependent speed, retires bullets off the top of the screen or on boss contact, and tracks boss HP.
- Sits between the input/player-position logic and the pixel renderer/boss logic.

Parameters:
- NSLOT, 4, number of bullet slots (1..8)
- COOLDOWN, 8, ticks between accepted shots
- BOSS_HP, 10'd200, boss HP loaded at reset
- DMG, 2, HP removed per bullet hit
- HALF_W, 41, boss hitbox half-width in pixels
- HALF_H, 24, boss hitbox half-height in pixels

Ports:
- clk_22  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle frame-advance strobe; all state updates only on cycles with tick=1
- fire  in  1  fire button level, sampled on tick
- reimux  in  10  player x
- reimuy  in  10  player y
- bossx  in  10  boss centre x
- bossy  in  10  boss centre y
- slot_x  out  NSLOT*10  packed bullet x; slot i at [10i+9:10i]
- slot_y  out  NSLOT*10  packed bullet y
- slot_active  out  NSLOT  bullet i live and drawable
- boss_hp  out  10  current boss HP
- hit_pulse  out  1  high for the single cycle following a tick on which at least one hit occurred
- boss_defeated  out  1  sticky; high once boss_hp reaches 0

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk_22.
- Reset values:
  - slot_x/slot_y = 0; slot_active = 0.
  - boss_hp = BOSS_HP.
  - hit_pulse = 0; boss_defeated = 0.
  - cooldown counter = 0.
  - State = ACTIVE.
- Reset mid-flight clears all slots immediately. tick is ignored on the reset cycle.
- States:
  - ACTIVE: normal operation.
  - DEFEATED: entered on the tick that drives boss_hp to 0. In DEFEATED, all slot_active = 0, fire is ignored, boss_hp is held at 0, and boss_defeated = 1. Exit only via rst.
- Per tick in ACTIVE, each active slot i is evaluated against its pre-tick y:
  - Hit test, done in 11-bit unsigned arithmetic with no underflow: x+HALF_W >= bossx AND x <= bossx+HALF_W AND y+HALF_H >= bossy AND y <= bossy+HALF_H.
  - Hit: clear active.
  - Else if y <= step(y): clear active (off top; wrap below 0 is forbidden).
  - Else: y <= y - step(y), where step = 1 if y <= 120, 2 if y <= 240, else 4. x is unchanged.
- Damage:
  - Let h = number of slots hit this tick. boss_hp <= boss_hp - h*DMG, saturating at 0.
  - If the result is 0, go to DEFEATED on the same tick.
  - hit_pulse = 1 on the cycle after any tick with h > 0, else 0.
- Fire: on a tick with fire=1, cooldown=0, and at least one slot inactive before this tick, the lowest-index inactive slot loads x=reimux, y=reimuy and sets active. The cooldown counter then loads COOLDOWN.
- A newly spawned slot does not move or hit-test on its spawn tick.
- A slot retired on this tick is not reusable until the next tick.
- If fire is accepted on the same tick as a defeating hit, the defeat wins and no spawn occurs.
- Cooldown decrements by 1 per tick when non-zero, saturating at 0. The reload on an accepted shot overrides the decrement.
- All slots full with fire=1: the shot is dropped and cooldown is unchanged.
- Outputs are registered; an update is visible the cycle after its tick. Non-tick cycles hold all state.

Test Plan:
- Reset, then one tick with fire=1, reimux=100, reimuy=300, boss far away (bossx=600, bossy=10) -> slot0 active at (100,300). Next tick: y=296. Ticks continue 4/2/1 per tick through the 240/120 zones until y<=1, then slot retires. boss_hp stays 200.
- fire held high for 40 ticks, COOLDOWN=8 -> spawns on ticks 1, 10, 19, 28, 37 into slots 0, 1, 2, 3, 0, with slot 0 reused only after it retired.
- Bullet at (320,100), boss at (320,60) -> slot clears on the first tick whose pre-tick y <= 84; boss_hp becomes 198; hit_pulse is high for exactly one cycle.
- Two slots hit on the same tick with boss_hp=3 -> boss_hp=0, boss_defeated=1, all slot_active=0, and subsequent fire is ignored.
- Boss at bossx=20 with bullet x=0 -> hit is detected with no underflow miss. Bullet at x=62 -> no hit.
- Assert rst while 3 slots are active -> the next cycle shows all outputs at their reset values, and a tick on the rst cycle has no effect.
